// File: rtl/game_turn_controller.sv
// Turn sequencer for the board-game datapath: player input, piece insertion,
// win check and turn advance, with per-turn timeout, draw and abandonment detection.
module game_turn_controller #(
   parameter int NUM_PLAYERS = 2,
   parameter int TURN_CYCLES = 50_000_000,
   parameter int MAX_MOVES   = 42,
   parameter int PID_W       = 3,
   parameter int TMR_W       = 26
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             fsm_reset,
   input  logic [NUM_PLAYERS-1:0]           valid_move,
   input  logic                             win_done,
   input  logic                             win_flag,
   input  logic [PID_W-1:0]                 winner_id,
   output logic [NUM_PLAYERS-1:0]           enable_input,
   output logic [NUM_PLAYERS-1:0]           insert_piece,
   output logic                             check_win,
   output logic [PID_W-1:0]                 turn,
   output logic [TMR_W-1:0]                 time_left,
   output logic [$clog2(MAX_MOVES+1)-1:0]   move_count,
   output logic [7:0]                       status,
   output logic                             write_status,
   output logic                             reset_board,
   output logic                             reset_inputs
);
   localparam int                MC_W   = $clog2(MAX_MOVES+1);
   localparam logic [PID_W-1:0]  LAST_P = PID_W'(NUM_PLAYERS);
   localparam logic [PID_W-1:0]  ONE_P  = PID_W'(1);
   localparam logic [MC_W-1:0]   MC_MAX = MC_W'(MAX_MOVES);
   localparam logic [TMR_W-1:0]  T_LOAD = TMR_W'(TURN_CYCLES-1);

   typedef enum logic [2:0] {
      S_CLEAR, S_WAIT, S_INSERT, S_CHECK, S_SKIP, S_NEXT, S_OVER
   } state_t;

   state_t                 state, state_nxt;
   logic [PID_W-1:0]       skip_cnt;
   logic                   over_seen;
   logic [NUM_PLAYERS-1:0] cur_oh;
   logic                   move_ok, last_skip, winner_ok, clr;
   logic [7:0]             win_code;

   assign clr       = !rst || fsm_reset;
   assign cur_oh    = NUM_PLAYERS'(1) << (turn - ONE_P);
   // only the current player's strobe counts; other bits are ignored
   assign move_ok   = |(valid_move & cur_oh);
   assign last_skip = (skip_cnt + ONE_P) == LAST_P;
   assign winner_ok = (winner_id != '0) && (winner_id <= LAST_P);
   assign win_code  = 8'h10 | 8'(winner_ok ? winner_id : turn);

   always_ff @(posedge clk) begin
      if (clr) state <= S_CLEAR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR:  state_nxt = S_WAIT;
         S_WAIT: begin
            if (move_ok)                state_nxt = S_INSERT;
            else if (time_left == '0)   state_nxt = S_SKIP;
         end
         S_INSERT: state_nxt = S_CHECK;
         S_CHECK: begin
            if (win_done) begin
               if (win_flag || move_count == MC_MAX) state_nxt = S_OVER;
               else                                  state_nxt = S_NEXT;
            end
         end
         S_SKIP:   state_nxt = last_skip ? S_OVER : S_NEXT;
         S_NEXT:   state_nxt = S_WAIT;
         S_OVER:   state_nxt = S_OVER;
         default:  state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         turn       <= ONE_P;
         time_left  <= '0;
         move_count <= '0;
         skip_cnt   <= '0;
         status     <= 8'h00;
         over_seen  <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: time_left <= T_LOAD;
            S_WAIT: begin
               if (!move_ok && time_left != '0) time_left <= time_left - TMR_W'(1);
            end
            S_INSERT: begin
               if (move_count != MC_MAX) move_count <= move_count + MC_W'(1);
               skip_cnt <= '0;
            end
            S_CHECK: begin
               if (win_done && win_flag)                    status <= win_code;
               else if (win_done && move_count == MC_MAX)   status <= 8'hD0;
            end
            S_SKIP: begin
               skip_cnt <= skip_cnt + ONE_P;
               if (last_skip) status <= 8'hA0;
            end
            S_NEXT: begin
               turn      <= (turn == LAST_P) ? ONE_P : turn + ONE_P;
               time_left <= T_LOAD;
            end
            S_OVER:  over_seen <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      enable_input = '0;
      insert_piece = '0;
      check_win    = 1'b0;
      write_status = 1'b0;
      reset_board  = 1'b0;
      reset_inputs = 1'b0;
      case (state)
         S_CLEAR: begin
            reset_board  = 1'b1;
            reset_inputs = 1'b1;
         end
         S_WAIT:   enable_input = cur_oh;
         S_INSERT: insert_piece = cur_oh;
         S_CHECK:  check_win    = 1'b1;
         S_OVER:   write_status = !over_seen;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_game_turn_controller.sv
// Bench for game_turn_controller: directed scenarios with literal expectations,
// then random stimulus, all checked every cycle against a behavioural game model.
module tb_game_turn_controller;
   localparam int NP = 3, TC = 8, MM = 4, PID_W = 3, TMR_W = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0, fsm_reset = 1'b0;
   logic [NP-1:0] valid_move = '0;
   logic          win_done = 1'b0, win_flag = 1'b0;
   logic [PID_W-1:0] winner_id = '0;
   logic [NP-1:0] enable_input, insert_piece;
   logic          check_win, write_status, reset_board, reset_inputs;
   logic [PID_W-1:0] turn;
   logic [TMR_W-1:0] time_left;
   logic [2:0]    move_count;
   logic [7:0]    status;

   int errors = 0, checks = 0;

   game_turn_controller #(.NUM_PLAYERS(NP), .TURN_CYCLES(TC), .MAX_MOVES(MM),
                          .PID_W(PID_W), .TMR_W(TMR_W)) dut (
      .clk(clk), .rst(rst), .fsm_reset(fsm_reset), .valid_move(valid_move),
      .win_done(win_done), .win_flag(win_flag), .winner_id(winner_id),
      .enable_input(enable_input), .insert_piece(insert_piece), .check_win(check_win),
      .turn(turn), .time_left(time_left), .move_count(move_count), .status(status),
      .write_status(write_status), .reset_board(reset_board), .reset_inputs(reset_inputs));

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting at %0t", nm, $time);
   endtask

   // Behavioural game model: phase names describe where the game is, plus
   // plain integer bookkeeping of the turn, timer, moves, skips and result.
   typedef enum int {M_CLEAR, M_WAIT, M_INSERT, M_CHECK, M_SKIP, M_NEXT, M_OVER} mph_t;
   mph_t m_ph = M_CLEAR;
   int   m_turn = 1, m_timer = 0, m_moves = 0, m_skips = 0, m_status = 0;
   bit   m_first = 1'b1, m_live = 1'b0;

   always @(posedge clk) begin
      if (!rst || fsm_reset) begin
         m_live = 1'b1; m_ph = M_CLEAR; m_turn = 1; m_timer = 0;
         m_moves = 0; m_skips = 0; m_status = 0; m_first = 1'b1;
      end else if (m_live) begin
         case (m_ph)
            M_CLEAR: begin m_ph = M_WAIT; m_timer = TC - 1; end
            M_WAIT: begin
               if (valid_move[m_turn-1]) m_ph = M_INSERT;
               else if (m_timer == 0)    m_ph = M_SKIP;
               else                      m_timer--;
            end
            M_INSERT: begin
               m_moves = (m_moves + 1 > MM) ? MM : m_moves + 1;
               m_skips = 0;
               m_ph = M_CHECK;
            end
            M_CHECK: begin
               if (win_done && win_flag) begin
                  m_status = 16 + ((winner_id >= 1 && winner_id <= NP) ? int'(winner_id) : m_turn);
                  m_ph = M_OVER;
               end else if (win_done && m_moves == MM) begin
                  m_status = 'hD0; m_ph = M_OVER;
               end else if (win_done) m_ph = M_NEXT;
            end
            M_SKIP: begin
               m_skips++;
               if (m_skips == NP) begin m_status = 'hA0; m_ph = M_OVER; end
               else m_ph = M_NEXT;
            end
            M_NEXT: begin m_turn = m_turn % NP + 1; m_timer = TC - 1; m_ph = M_WAIT; end
            M_OVER: m_first = 1'b0;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         cmp("m.enable_input", enable_input, (m_ph == M_WAIT)   ? (1 << (m_turn-1)) : 0);
         cmp("m.insert_piece", insert_piece, (m_ph == M_INSERT) ? (1 << (m_turn-1)) : 0);
         cmp("m.check_win",    check_win,    m_ph == M_CHECK);
         cmp("m.reset_board",  {reset_board, reset_inputs}, (m_ph == M_CLEAR) ? 3 : 0);
         cmp("m.write_status", write_status, (m_ph == M_OVER) && m_first);
         cmp("m.turn",         turn,         m_turn);
         cmp("m.time_left",    time_left,    m_timer);
         cmp("m.move_count",   move_count,   m_moves);
         cmp("m.status",       status,       m_status);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic new_game();
      fsm_reset = 1'b1; tick(); fsm_reset = 1'b0; tick();
   endtask

   task automatic wait_en(input string nm);
      int n = 0;
      while (enable_input == '0 && n < 60) begin tick(); n++; end
      if (enable_input == '0) tmo(nm);
   endtask

   task automatic wait_turn_en(input int p, input string nm);
      int n = 0;
      while (!(turn == PID_W'(p) && enable_input != '0) && n < 80) begin tick(); n++; end
      if (!(turn == PID_W'(p) && enable_input != '0)) tmo(nm);
   endtask

   task automatic wait_ws(input string nm);
      int n = 0;
      while (!write_status && n < 100) begin tick(); n++; end
      if (!write_status) tmo(nm);
   endtask

   // One accepted move by whoever holds the turn, answered by the win checker.
   task automatic play(input logic flag, input logic [PID_W-1:0] wid);
      int n = 0;
      wait_en("play.en");
      valid_move = enable_input; tick(); valid_move = '0;
      while (!check_win && n < 5) begin tick(); n++; end
      if (!check_win) tmo("play.check");
      win_done = 1'b1; win_flag = flag; winner_id = wid; tick();
      win_done = 1'b0; win_flag = 1'b0;
   endtask

   initial begin
      int ws_cnt;
      // 1: reset and first turn
      tick(); tick();
      cmp("rst.reset_board", {reset_board, reset_inputs}, 3);
      cmp("rst.status", status, 8'h00);
      cmp("rst.turn", turn, 1);
      cmp("rst.time_left", time_left, 0);
      rst = 1'b1; tick();
      cmp("t1.enable", enable_input, 3'b001);
      cmp("t1.time_left", time_left, 7);
      tick();
      cmp("t1.countdown", time_left, 6);

      // 2: player 1 move, no win
      valid_move = 3'b001; tick(); valid_move = '0;
      cmp("mv1.insert", insert_piece, 3'b001);
      tick();
      cmp("mv1.move_count", move_count, 1);
      cmp("mv1.check_win", check_win, 1);
      win_done = 1'b1; tick(); win_done = 1'b0;
      cmp("mv1.check_drop", check_win, 0);
      tick();
      cmp("mv1.turn", turn, 2);
      cmp("mv1.enable", enable_input, 3'b010);

      // 3: player 2 wins after a slow checker, then OVER ignores moves
      valid_move = 3'b010; tick(); valid_move = '0; tick(); tick(); tick();
      cmp("win.check_held", check_win, 1);
      win_done = 1'b1; win_flag = 1'b1; winner_id = 3'd2; tick();
      win_done = 1'b0; win_flag = 1'b0; winner_id = '0;
      cmp("win.status", status, 8'h12);
      cmp("win.write_status", write_status, 1);
      valid_move = 3'b111; ws_cnt = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (write_status) ws_cnt++; end
      valid_move = '0;
      cmp("win.ws_once", ws_cnt, 0);
      cmp("win.hold", {status, 5'(move_count)}, {8'h12, 5'd2});
      fsm_reset = 1'b1; tick(); fsm_reset = 1'b0;
      cmp("nr.clear", {reset_board, status, 3'(move_count), turn}, {1'b1, 8'h00, 3'd0, 3'd1});
      tick();

      // 4a: everyone times out
      wait_ws("abandon.ws");
      cmp("abandon.status", status, 8'hA0);
      cmp("abandon.turn", turn, 3);
      // 4b: a move after two skips resets the abandonment count
      new_game();
      wait_turn_en(3, "skip2.turn3");
      play(1'b0, '0);
      wait_turn_en(3, "skip2b.turn3");
      cmp("skip2.still_playing", status, 8'h00);
      wait_ws("skip2.ws");
      cmp("skip2.abandon", status, 8'hA0);

      // 5: board fills with no winner
      new_game();
      for (int i = 0; i < 4; i++) play(1'b0, '0);
      cmp("draw.status", status, 8'hD0);
      cmp("draw.move_count", move_count, 4);
      cmp("draw.ws", write_status, 1);

      // 6a: other players' strobes are ignored
      new_game();
      wait_en("ign.en");
      valid_move = 3'b110; tick(); tick(); tick();
      cmp("ign.time_left", time_left, 4);
      cmp("ign.enable", enable_input, 3'b001);
      valid_move = '0;
      // 6b: a move on the last cycle beats the timeout
      for (int n = 0; n < 10 && time_left != 0; n++) tick();
      if (time_left != 0) tmo("edge.t0");
      valid_move = 3'b001; tick(); valid_move = '0;
      cmp("edge.insert", insert_piece, 3'b001);
      // 6c: hard reset in the middle of a check
      tick();
      cmp("rc.check", check_win, 1);
      rst = 1'b0; tick(); rst = 1'b1;
      cmp("rc.clear", {reset_board, status, 3'(move_count)}, {1'b1, 8'h00, 3'd0});

      // random play against the model
      for (int i = 0; i < 3000; i++) begin
         valid_move = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
         win_done   = ($urandom_range(0, 2) == 0);
         win_flag   = ($urandom_range(0, 3) == 0);
         winner_id  = PID_W'($urandom);
         fsm_reset  = ($urandom_range(0, 99) == 0);
         rst        = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst = 1'b1; fsm_reset = 1'b0; valid_move = '0; win_done = 1'b0;
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/game_turn_controller.md
Name: game_turn_controller

Overview:
- Parametrised next-generation turn controller for the board-game datapath.
- Sequences N players through input, piece insertion, win check and turn advance.
- Owns an internal per-turn countdown timer and a move counter, and detects draw (board full) and abandonment (every player times out in a row).
- Sits between the per-player input blocks, the board/insert logic and the win checker; drives the status register write.

Parameters:
- NUM_PLAYERS, 2, number of players (2..4).
- TURN_CYCLES, 50_000_000, clock cycles allowed per turn (>=2).
- MAX_MOVES, 42, board cell count; this many accepted moves with no win is a draw.
- PID_W, 3, width of player id; must be >= clog2(NUM_PLAYERS+1).
- TMR_W, 26, timer width; must be >= clog2(TURN_CYCLES).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous active-low reset; sampled only at the clk rising edge.
- fsm_reset  in  1  synchronous new-game request, active high.
- valid_move  in  NUM_PLAYERS  per-player move-valid strobe; bit i is player i+1.
- win_done  in  1  win checker result valid.
- win_flag  in  1  win found; qualified by win_done.
- winner_id  in  PID_W  winning player number, 1-based.
- enable_input  out  NUM_PLAYERS  one-hot enable for the current player.
- insert_piece  out  NUM_PLAYERS  one-hot 1-cycle insert pulse.
- check_win  out  1  win-check request, held until win_done.
- turn  out  PID_W  current player number, 1-based.
- time_left  out  TMR_W  remaining cycles in the current turn.
- move_count  out  clog2(MAX_MOVES+1)  accepted moves this game.
- status  out  8  game status code.
- write_status  out  1  1-cycle strobe when status becomes final.
- reset_board  out  1  board clear.
- reset_inputs  out  1  input block clear.

Behaviour:
- Priority: rst low > fsm_reset > normal operation.
- Both rst low and fsm_reset force state CLEAR at the next edge. The counters, skip_cnt and status also reset then, so a mid-game reset is always clean.
- Reset values: state CLEAR, turn=1, status=8'h00, move_count=0, time_left=0, skip_cnt=0.
- Outputs in CLEAR: reset_board=1, reset_inputs=1; all other strobes/enables are 0.
- Status codes:
  - 8'h00 playing.
  - 8'h10|p: player p wins.
  - 8'hD0: draw.
  - 8'hA0: abandoned.
- Outputs are Moore decodes of the registered state plus the registered turn.
- CLEAR (1 cycle) -> WAIT. On leaving CLEAR, time_left loads TURN_CYCLES-1.
- WAIT:
  - enable_input = onehot(turn-1).
  - Only valid_move[turn-1] is honoured; other bits are ignored.
  - Valid move -> INSERT.
  - Else if time_left==0 -> SKIP.
  - Else time_left decrements.
  - A valid move on the same cycle time_left==0: the move wins, no skip.
- INSERT (1 cycle):
  - insert_piece = onehot(turn-1).
  - move_count increments, saturating at MAX_MOVES.
  - skip_cnt clears.
  - -> CHECK.
- CHECK:
  - check_win=1.
  - Stays in CHECK while win_done=0; there is no timeout.
  - win_done=1 with win_flag=1 -> OVER. status=8'h10|winner_id if winner_id is in 1..NUM_PLAYERS, otherwise 8'h10|turn.
  - win_done=1, win_flag=0, move_count==MAX_MOVES -> OVER, status=8'hD0.
  - Otherwise -> NEXT.
- SKIP (1 cycle): skip_cnt increments. If skip_cnt+1==NUM_PLAYERS -> OVER with status=8'hA0; else -> NEXT.
- NEXT (1 cycle):
  - turn = (turn==NUM_PLAYERS) ? 1 : turn+1.
  - time_left reloads TURN_CYCLES-1.
  - -> WAIT.
- OVER:
  - write_status=1 only on the first cycle in OVER; status is already valid that cycle.
  - Enables and strobes are 0. status, turn and move_count hold.
  - Leaves only via fsm_reset or rst.
- Latency: valid move sampled at edge k -> insert_piece during cycle k+1 -> check_win from k+2.
- Non-win path: enable_input for the next player returns no earlier than 2 cycles after win_done.

Test Plan:
Bench parameters: NUM_PLAYERS=3, TURN_CYCLES=8, MAX_MOVES=4.
1. rst=0 for 2 cycles, then rst=1 -> reset_board=reset_inputs=1 for 1 cycle; then enable_input=3'b001, turn=1, time_left=7 counting down.
2. valid_move=3'b001 in WAIT, then win_done=1, win_flag=0 two cycles later -> insert_piece=3'b001 for 1 cycle; move_count=1; turn=2, enable_input=3'b010.
3. Player 2 moves; during CHECK present win_done=1, win_flag=1, winner_id=2 -> status=8'h12, write_status high exactly 1 cycle; FSM stays in OVER for 20 cycles ignoring valid_move; fsm_reset=1 -> CLEAR, status=8'h00, move_count=0, turn=1.
4. No moves for 3x8 cycles -> turns 1->2->3 each skipped; third timeout gives status=8'hA0 with write_status pulse. Separately, a move after 2 skips clears skip_cnt and the game continues.
5. Four accepted moves, all with win_flag=0 -> after the 4th win_done, status=8'hD0, move_count=4.
6. valid_move=3'b110 while turn=1 -> ignored, timer keeps counting. Second case: valid_move[0] asserted exactly when time_left=0 -> INSERT, not skip. Third case: rst=0 asserted during CHECK -> CLEAR next edge.
